imem_loader: RTL and testbench

Program loader that streams instruction words from a valid/ready source into instruction memory, then reads them back to verify a checksum before releasing the CPU to fetch. It is the write-side counterpart of the fetch path: fetch reads `mem` at PC offsets, and `imem_loader` fills `mem` at those same offsets. It sits between the test harness or boot source and the `mem` instruction-memory port, and owns that port until `done`.

---
 rtl/imem_loader.sv | 96 +++++++++
 tb/tb_imem_loader.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// imem_loader: streams an instruction image into memory, then verifies it by checksum readback
module imem_loader #(
  parameter logic [31:0] PC_BASE_ADDR = 32'h80020000,
  parameter int          MAX_WORDS    = 1024,
  parameter bit          VERIFY       = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  input  logic        in_last,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_data_in,
  input  logic [31:0] mem_data_out,
  output logic        mem_rw,
  output logic        mem_en,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [1:0]  err_code,
  output logic [31:0] word_count,
  output logic [31:0] fetch_pc
);
  typedef enum logic [2:0] {IDLE, LOAD, VRD, VCMP, DONE, ERROR} state_t;
  localparam logic [31:0] MAXW = 32'(MAX_WORDS);
  state_t state, state_n;
  logic [31:0] wsum, rsum, rd_idx;
  logic rd_p1, rd_p2;
  logic beat, ovf, wr, rd_last, sums_ok;
  assign in_ready = state == LOAD;
  assign busy     = state inside {LOAD, VRD, VCMP};
  assign done     = state == DONE;
  assign error    = state == ERROR;
  assign fetch_pc = done ? PC_BASE_ADDR : 32'd0;
  assign beat     = in_valid & in_ready;
  assign ovf      = beat && word_count == MAXW;
  assign wr       = beat & ~ovf;
  assign rd_last  = rd_idx == word_count - 32'd1;
  assign sums_ok  = !VERIFY || rsum == wsum;
  // next-state: readback drains through a two-stage pipe before the sums are compared
  always_comb begin
    state_n = state;
    case (state)
      IDLE, DONE, ERROR: state_n = start ? LOAD : state;
      LOAD:              state_n = ovf ? ERROR : (wr && in_last) ? (VERIFY ? VRD : VCMP) : LOAD;
      VRD:               state_n = rd_last ? VCMP : VRD;
      VCMP:              state_n = (rd_p1 || rd_p2) ? VCMP : sums_ok ? DONE : ERROR;
      default:           state_n = IDLE;
    endcase
  end
  // state register
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else state <= state_n;
  end
  // registered memory port, counters and checksums
  always_ff @(posedge clock) begin
    if (reset) begin
      mem_addr    <= '0;
      mem_data_in <= '0;
      mem_rw      <= 1'b1;
      mem_en      <= 1'b0;
      word_count  <= '0;
      wsum        <= '0;
      rsum        <= '0;
      rd_idx      <= '0;
      rd_p1       <= 1'b0;
      rd_p2       <= 1'b0;
      err_code    <= '0;
    end else if (start && !busy) begin
      mem_rw      <= 1'b1;
      mem_en      <= 1'b0;
      word_count  <= '0;
      wsum        <= '0;
      rsum        <= '0;
      rd_idx      <= '0;
      rd_p1       <= 1'b0;
      rd_p2       <= 1'b0;
      err_code    <= '0;
    end else begin
      mem_en      <= wr || state == VRD;
      mem_rw      <= !wr;
      mem_addr    <= state == VRD ? {rd_idx[29:0], 2'b00} : wr ? {word_count[29:0], 2'b00} : mem_addr;
      mem_data_in <= wr ? in_data : mem_data_in;
      word_count  <= wr ? word_count + 32'd1 : word_count;
      wsum        <= wr ? wsum + in_data : wsum;
      rd_idx      <= state == VRD ? rd_idx + 32'd1 : rd_idx;
      rd_p1       <= state == VRD;
      rd_p2       <= rd_p1;
      rsum        <= rd_p2 ? rsum + mem_data_out : rsum;
      err_code    <= ovf ? 2'd1 : (state == VCMP && state_n == ERROR) ? 2'd2 : err_code;
    end
  end
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed checks of the loader with default, small-capacity and no-verify builds
module tb_imem_loader;
  logic clock = 1'b0;
  logic reset = 1'b1;
  logic start [3], in_valid [3], in_last [3], in_ready [3];
  logic mem_rw [3], mem_en [3], busy [3], done [3], error [3], clr [3];
  logic [31:0] in_data [3], mem_addr [3], mem_data_in [3], mem_data_out [3];
  logic [31:0] word_count [3], fetch_pc [3];
  logic [1:0] err_code [3];
  logic [31:0] mem [3][16];
  logic [31:0] img [8];
  int nwr [3], nrd [3];
  int edges = 0;
  int tests = 0;
  int fails = 0;
  logic corrupt = 1'b0;
  localparam logic [31:0] FILL = 32'hDEADBEEF;

  always #5 clock = ~clock;
  always @(posedge clock) edges <= edges + 1;

  // instance 0: defaults; 1: MAX_WORDS=4; 2: VERIFY=0
  for (genvar g = 0; g < 3; g++) begin : g_dut
    imem_loader #(.MAX_WORDS(g == 1 ? 4 : 1024), .VERIFY(g != 2)) u_dut (
      .clock(clock), .reset(reset), .start(start[g]), .in_valid(in_valid[g]),
      .in_ready(in_ready[g]), .in_data(in_data[g]), .in_last(in_last[g]),
      .mem_addr(mem_addr[g]), .mem_data_in(mem_data_in[g]), .mem_data_out(mem_data_out[g]),
      .mem_rw(mem_rw[g]), .mem_en(mem_en[g]), .busy(busy[g]), .done(done[g]),
      .error(error[g]), .err_code(err_code[g]), .word_count(word_count[g]), .fetch_pc(fetch_pc[g])
    );
  end

  // synchronous-read memory per instance; optional bit flip on offset 8 for instance 0
  always @(posedge clock) begin
    for (int i = 0; i < 3; i++) begin
      if (clr[i]) begin
        for (int j = 0; j < 16; j++) mem[i][j] <= FILL;
        nwr[i] <= 0;
        nrd[i] <= 0;
      end else if (mem_en[i] && !mem_rw[i]) begin
        mem[i][mem_addr[i][5:2]] <= mem_data_in[i];
        nwr[i] <= nwr[i] + 1;
      end else if (mem_en[i]) begin
        mem_data_out[i] <= mem[i][mem_addr[i][5:2]] ^ ((corrupt && i == 0 && mem_addr[i] == 32'd8) ? 32'd1 : 32'd0);
        nrd[i] <= nrd[i] + 1;
      end
    end
  end

  task automatic clear(input int i);
    clr[i] = 1'b1;
    @(posedge clock); #1;
    clr[i] = 1'b0;
  endtask

  task automatic pulse(input int i);
    start[i] = 1'b1;
    @(posedge clock); #1;
    start[i] = 1'b0;
  endtask

  task automatic stream(input int i, input int n, input bit stall, output int e0, output int ed);
    e0 = 0;
    for (int k = 0; k < n; k++) begin
      if (stall && k > 0) begin
        in_valid[i] = 1'b0;
        @(posedge clock); #1;
      end
      in_valid[i] = 1'b1;
      in_data[i]  = img[k];
      in_last[i]  = k == n - 1;
      @(posedge clock); #1;
      if (k == 0) e0 = edges;
    end
    in_valid[i] = 1'b0;
    in_last[i]  = 1'b0;
    for (int t = 0; t < 40 && !done[i] && !error[i]; t++) begin
      @(posedge clock); #1;
    end
    ed = edges;
  endtask

  task automatic test_reset;
    tests++; if (in_ready[0] !== 1'b0) begin fails++; $display("FAIL reset in_ready got %b want 0", in_ready[0]); end
    tests++; if (busy[0] !== 1'b0) begin fails++; $display("FAIL reset busy got %b want 0", busy[0]); end
    tests++; if (done[0] !== 1'b0 || error[0] !== 1'b0) begin fails++; $display("FAIL reset done/error got %b/%b want 0/0", done[0], error[0]); end
    tests++; if (err_code[0] !== 2'd0) begin fails++; $display("FAIL reset err_code got %0d want 0", err_code[0]); end
    tests++; if (word_count[0] !== 32'd0 || fetch_pc[0] !== 32'd0) begin fails++; $display("FAIL reset count/pc got %h/%h want 0/0", word_count[0], fetch_pc[0]); end
    tests++; if (mem_en[0] !== 1'b0 || mem_rw[0] !== 1'b1 || mem_addr[0] !== 32'd0) begin fails++; $display("FAIL reset mem port en=%b rw=%b addr=%h want 0/1/0", mem_en[0], mem_rw[0], mem_addr[0]); end
    reset = 1'b0;
    @(posedge clock); #1;
  endtask

  task automatic test_load;
    int e0, ed;
    clear(0);
    pulse(0);
    tests++; if (in_ready[0] !== 1'b1) begin fails++; $display("FAIL load in_ready after start got %b want 1", in_ready[0]); end
    stream(0, 4, 1'b0, e0, ed);
    tests++; if (ed - e0 !== 10) begin fails++; $display("FAIL load done latency got %0d want 10", ed - e0); end
    tests++; if (done[0] !== 1'b1 || error[0] !== 1'b0) begin fails++; $display("FAIL load done/error got %b/%b want 1/0", done[0], error[0]); end
    tests++; if (word_count[0] !== 32'd4) begin fails++; $display("FAIL load word_count got %0d want 4", word_count[0]); end
    tests++; if (fetch_pc[0] !== 32'h80020000) begin fails++; $display("FAIL load fetch_pc got %h want 80020000", fetch_pc[0]); end
    tests++; if (in_ready[0] !== 1'b0 || busy[0] !== 1'b0 || mem_en[0] !== 1'b0) begin fails++; $display("FAIL load idle port ready=%b busy=%b en=%b want 0", in_ready[0], busy[0], mem_en[0]); end
    for (int k = 0; k < 4; k++) begin
      tests++; if (mem[0][k] !== img[k]) begin fails++; $display("FAIL load mem[%0d] got %h want %h", k * 4, mem[0][k], img[k]); end
    end
    tests++; if (mem[0][4] !== FILL) begin fails++; $display("FAIL load mem[16] got %h want %h", mem[0][4], FILL); end
    tests++; if (nwr[0] !== 4 || nrd[0] !== 4) begin fails++; $display("FAIL load writes/reads got %0d/%0d want 4/4", nwr[0], nrd[0]); end
  endtask

  task automatic test_stall;
    int e0, ed;
    clear(0);
    pulse(0);
    stream(0, 4, 1'b1, e0, ed);
    tests++; if (ed - e0 !== 13) begin fails++; $display("FAIL stall done latency got %0d want 13", ed - e0); end
    tests++; if (done[0] !== 1'b1 || word_count[0] !== 32'd4) begin fails++; $display("FAIL stall done/count got %b/%0d want 1/4", done[0], word_count[0]); end
    for (int k = 0; k < 4; k++) begin
      tests++; if (mem[0][k] !== img[k]) begin fails++; $display("FAIL stall mem[%0d] got %h want %h", k * 4, mem[0][k], img[k]); end
    end
    tests++; if (nwr[0] !== 4) begin fails++; $display("FAIL stall writes got %0d want 4", nwr[0]); end
  endtask

  task automatic test_overflow;
    int e0, ed;
    img[4] = 32'h12345678;
    clear(1);
    pulse(1);
    stream(1, 5, 1'b0, e0, ed);
    tests++; if (ed - e0 !== 4) begin fails++; $display("FAIL ovf error latency got %0d want 4", ed - e0); end
    tests++; if (error[1] !== 1'b1 || done[1] !== 1'b0) begin fails++; $display("FAIL ovf error/done got %b/%b want 1/0", error[1], done[1]); end
    tests++; if (err_code[1] !== 2'd1) begin fails++; $display("FAIL ovf err_code got %0d want 1", err_code[1]); end
    tests++; if (in_ready[1] !== 1'b0) begin fails++; $display("FAIL ovf in_ready got %b want 0", in_ready[1]); end
    tests++; if (nwr[1] !== 4) begin fails++; $display("FAIL ovf writes got %0d want 4", nwr[1]); end
    tests++; if (mem[1][3] !== img[3] || mem[1][4] !== FILL) begin fails++; $display("FAIL ovf mem[12]/mem[16] got %h/%h want %h/%h", mem[1][3], mem[1][4], img[3], FILL); end
  endtask

  task automatic test_corrupt;
    int e0, ed;
    clear(0);
    corrupt = 1'b1;
    pulse(0);
    stream(0, 4, 1'b0, e0, ed);
    corrupt = 1'b0;
    tests++; if (ed - e0 !== 10) begin fails++; $display("FAIL corrupt error latency got %0d want 10", ed - e0); end
    tests++; if (error[0] !== 1'b1 || done[0] !== 1'b0) begin fails++; $display("FAIL corrupt error/done got %b/%b want 1/0", error[0], done[0]); end
    tests++; if (err_code[0] !== 2'd2) begin fails++; $display("FAIL corrupt err_code got %0d want 2", err_code[0]); end
    tests++; if (fetch_pc[0] !== 32'd0) begin fails++; $display("FAIL corrupt fetch_pc got %h want 0", fetch_pc[0]); end
  endtask

  task automatic test_reset_mid;
    int e0, ed;
    clear(0);
    pulse(0);
    for (int k = 0; k < 2; k++) begin
      in_valid[0] = 1'b1;
      in_data[0]  = img[k];
      @(posedge clock); #1;
    end
    in_valid[0] = 1'b0;
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    tests++; if (busy[0] !== 1'b0 || in_ready[0] !== 1'b0 || done[0] !== 1'b0 || error[0] !== 1'b0) begin fails++; $display("FAIL midrst busy/ready/done/error got %b%b%b%b want 0000", busy[0], in_ready[0], done[0], error[0]); end
    tests++; if (word_count[0] !== 32'd0 || err_code[0] !== 2'd0) begin fails++; $display("FAIL midrst count/err_code got %0d/%0d want 0/0", word_count[0], err_code[0]); end
    tests++; if (mem_en[0] !== 1'b0 || mem_rw[0] !== 1'b1 || mem_addr[0] !== 32'd0) begin fails++; $display("FAIL midrst mem port en=%b rw=%b addr=%h want 0/1/0", mem_en[0], mem_rw[0], mem_addr[0]); end
    tests++; if (mem[0][1] !== 32'h20090007 || mem[0][2] !== FILL) begin fails++; $display("FAIL midrst partial image got %h/%h want 20090007/%h", mem[0][1], mem[0][2], FILL); end
    img[0] = 32'h0000000C;
    pulse(0);
    stream(0, 1, 1'b0, e0, ed);
    tests++; if (ed - e0 !== 4) begin fails++; $display("FAIL one-word done latency got %0d want 4", ed - e0); end
    tests++; if (done[0] !== 1'b1 || word_count[0] !== 32'd1) begin fails++; $display("FAIL one-word done/count got %b/%0d want 1/1", done[0], word_count[0]); end
    tests++; if (mem[0][0] !== 32'h0000000C) begin fails++; $display("FAIL one-word mem[0] got %h want 0000000c", mem[0][0]); end
  endtask

  task automatic test_back_to_back;
    int e0, ed;
    img[0] = 32'hAAAA0001;
    img[1] = 32'h00000002;
    clear(2);
    pulse(2);
    stream(2, 2, 1'b0, e0, ed);
    tests++; if (ed - e0 !== 2) begin fails++; $display("FAIL noverify done latency got %0d want 2", ed - e0); end
    tests++; if (done[2] !== 1'b1 || word_count[2] !== 32'd2) begin fails++; $display("FAIL noverify done/count got %b/%0d want 1/2", done[2], word_count[2]); end
    tests++; if (nrd[2] !== 0 || nwr[2] !== 2) begin fails++; $display("FAIL noverify reads/writes got %0d/%0d want 0/2", nrd[2], nwr[2]); end
    tests++; if (mem[2][0] !== img[0] || mem[2][1] !== img[1]) begin fails++; $display("FAIL noverify mem got %h/%h want %h/%h", mem[2][0], mem[2][1], img[0], img[1]); end
    pulse(2);
    tests++; if (word_count[2] !== 32'd0 || done[2] !== 1'b0 || in_ready[2] !== 1'b1) begin fails++; $display("FAIL restart count/done/ready got %0d/%b/%b want 0/0/1", word_count[2], done[2], in_ready[2]); end
    in_valid[2] = 1'b1;
    in_data[2]  = img[0];
    start[2]    = 1'b1;
    @(posedge clock); #1;
    start[2]    = 1'b0;
    in_data[2]  = img[1];
    in_last[2]  = 1'b1;
    @(posedge clock); #1;
    in_valid[2] = 1'b0;
    in_last[2]  = 1'b0;
    tests++; if (word_count[2] !== 32'd2 || busy[2] !== 1'b1) begin fails++; $display("FAIL busy-start count/busy got %0d/%b want 2/1", word_count[2], busy[2]); end
    @(posedge clock); #1;
    tests++; if (done[2] !== 1'b1 || word_count[2] !== 32'd2) begin fails++; $display("FAIL busy-start done/count got %b/%0d want 1/2", done[2], word_count[2]); end
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      start[i] = 1'b0;
      in_valid[i] = 1'b0;
      in_last[i] = 1'b0;
      in_data[i] = '0;
      clr[i] = 1'b1;
    end
    img[0] = 32'h20080005;
    img[1] = 32'h20090007;
    img[2] = 32'h01095020;
    img[3] = 32'h00000000;
    repeat (3) @(posedge clock);
    #1;
    for (int i = 0; i < 3; i++) clr[i] = 1'b0;
    test_reset;
    test_load;
    test_stall;
    test_overflow;
    test_corrupt;
    test_reset_mid;
    img[0] = 32'h20080005;
    test_back_to_back;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
